verdict_ram_scheduler: RTL and testbench

//  Owns the single-port flow-verdict RAM (DEPTH x WORD_W) behind the entropy engine.

---
 rtl/verdict_ram_scheduler_pkg.sv | 19 +
 rtl/verdict_ram_scheduler_packer.sv | 89 ++++++++
 rtl/verdict_ram_scheduler.sv | 152 +++++++++++++++
 tb/tb_verdict_ram_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/verdict_ram_scheduler_pkg.sv
// verdict_ram_scheduler_pkg: shared defaults and FSM encoding for the verdict RAM scheduler
//   DEF_WORD_W  : RAM word width, which is also the number of verdict bits per word
//   DEF_ADDR_W  : RAM address width (DEPTH = 2**ADDR_W)
//   DEF_RAM_LAT : RAM read latency in cycles
//   FLOW_CNT_W  : width of the batch total and the verdict counter
//   state_t     : port scheduler states
package verdict_ram_scheduler_pkg;
    localparam int DEF_WORD_W  = 64;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_RAM_LAT = 1;
    localparam int FLOW_CNT_W  = 16;
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDWAIT
    } state_t;
endpackage

// File: rtl/verdict_ram_scheduler_packer.sv
// verdict_ram_scheduler_packer: packs per-flow verdict bits into RAM words, LSB first
//   i_clk, i_rst          : clock, sync active-high reset
//   i_verdict_valid/_bit  : one verdict per cycle
//   i_flow_total          : batch size, latched on the first verdict of a batch
//   i_buf_free            : the one-deep write buffer can take a word this cycle
//   i_finish              : final write retired; close the batch
//   o_word_done/_word/_addr : completed word handed to the write buffer
//   o_closing             : last verdict of the batch has been counted
//   o_open                : a batch is in progress
//   o_overflow            : sticky, a verdict was dropped
module verdict_ram_scheduler_packer
    import verdict_ram_scheduler_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_verdict_valid,
    input  logic                  i_verdict_bit,
    input  logic [FLOW_CNT_W-1:0] i_flow_total,
    input  logic                  i_buf_free,
    input  logic                  i_finish,
    output logic                  o_word_done,
    output logic [WORD_W-1:0]     o_word,
    output logic [ADDR_W-1:0]     o_word_addr,
    output logic                  o_closing,
    output logic                  o_open,
    output logic                  o_overflow
);
    localparam int BIT_W = $clog2(WORD_W);
    logic                  r_open;
    logic                  r_closing;
    logic                  r_overflow;
    logic [FLOW_CNT_W-1:0] r_total;
    logic [FLOW_CNT_W-1:0] r_count;
    logic [WORD_W-1:0]     r_shift;
    logic [FLOW_CNT_W-1:0] w_cnt;
    logic [FLOW_CNT_W-1:0] w_tot;
    logic [FLOW_CNT_W-1:0] w_cnt_nxt;
    logic                  w_take;
    logic                  w_in_cap;
    logic                  w_last;
    logic                  w_full;
    logic                  w_cand;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_drop;
    logic [WORD_W-1:0]     w_word;
    // The verdict count doubles as the bit/word index: word = cnt/WORD_W, bit = cnt%WORD_W.
    always_comb begin
        w_cnt     = r_open ? r_count : '0;
        w_tot     = r_open ? r_total : i_flow_total;
        w_cnt_nxt = w_cnt + 1'b1;
        w_take    = i_verdict_valid && !r_closing && (w_tot != '0);
        w_in_cap  = (w_cnt >> (ADDR_W + BIT_W)) == '0;
        w_last    = w_cnt_nxt == w_tot;
        w_full    = w_cnt[BIT_W-1:0] == BIT_W'(WORD_W - 1);
        w_cand    = w_take && w_in_cap && (w_full || w_last);
        // A word that cannot be handed over holds the packer still and drops this verdict.
        w_stall   = w_cand && !i_buf_free;
        w_accept  = w_take && !w_stall;
        w_drop    = i_verdict_valid && (!w_take || !w_in_cap || w_stall);
        w_word    = r_shift | (WORD_W'(i_verdict_bit) << w_cnt[BIT_W-1:0]);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst || i_finish) begin
            r_open    <= 1'b0;
            r_closing <= 1'b0;
            r_total   <= '0;
            r_count   <= '0;
            r_shift   <= '0;
        end else if (w_accept) begin
            r_open    <= 1'b1;
            r_closing <= w_last;
            r_count   <= w_cnt_nxt;
            r_shift   <= (w_cand || !w_in_cap) ? '0 : w_word;
            if (!r_open)
                r_total <= i_flow_total;
        end
        r_overflow <= i_rst ? 1'b0 : (r_overflow || w_drop);
    end
    assign o_word_done = w_cand && i_buf_free;
    assign o_word      = w_word;
    assign o_word_addr = w_cnt[BIT_W +: ADDR_W];
    assign o_closing   = r_closing;
    assign o_open      = r_open;
    assign o_overflow  = r_overflow;
endmodule

// File: rtl/verdict_ram_scheduler.sv
// verdict_ram_scheduler: owns the single-port flow-verdict RAM, clears it, packs verdicts, arbitrates writes over reads
//   i_clk, i_rst        : clock, sync active-high reset
//   i_verdict_valid/_bit, i_flow_total : verdict stream and batch size
//   i_rd_req, i_rd_addr : host read request, held until o_rd_ack
//   o_rd_ack, o_rd_data : one-cycle ack with registered read data
//   o_done              : one-cycle pulse once a batch is fully written
//   o_overflow          : sticky, a verdict was dropped
//   o_busy              : clearing the RAM or a batch is open
//   o_ram_en/_we/_addr/_din, i_ram_dout : external RAM port
module verdict_ram_scheduler
    import verdict_ram_scheduler_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RAM_LAT = DEF_RAM_LAT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_verdict_valid,
    input  logic                  i_verdict_bit,
    input  logic [FLOW_CNT_W-1:0] i_flow_total,
    input  logic                  i_rd_req,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic                  o_rd_ack,
    output logic [WORD_W-1:0]     o_rd_data,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [WORD_W-1:0]     o_ram_din,
    input  logic [WORD_W-1:0]     i_ram_dout
);
    localparam int DEPTH = 2**ADDR_W;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_wr_buf;
    logic              r_wr_pend;
    logic [7:0]        r_wait;
    logic              r_rd_ack;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_done;
    logic              w_buf_free;
    logic              w_finish;
    logic              w_rd_fire;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_closing;
    logic              w_open;
    logic              w_overflow;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [WORD_W-1:0] w_ram_din;
    // The buffer is free if empty or being written out this very cycle.
    assign w_buf_free = !r_wr_pend || (r_state == ST_WR);
    assign w_finish   = w_closing && w_buf_free;
    verdict_ram_scheduler_packer #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_verdict_valid (i_verdict_valid),
        .i_verdict_bit   (i_verdict_bit),
        .i_flow_total    (i_flow_total),
        .i_buf_free      (w_buf_free),
        .i_finish        (w_finish),
        .o_word_done     (w_word_done),
        .o_word          (w_word),
        .o_word_addr     (w_word_addr),
        .o_closing       (w_closing),
        .o_open          (w_open),
        .o_overflow      (w_overflow)
    );
    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_din   = '0;
        w_rd_fire   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clr_addr;
                w_state_nxt = (r_clr_addr == ADDR_W'(DEPTH - 1)) ? ST_IDLE : ST_CLEAR;
            end
            ST_IDLE:
                w_state_nxt = r_wr_pend ? ST_WR : (i_rd_req ? ST_RD : ST_IDLE);
            ST_WR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_wr_addr;
                w_ram_din   = r_wr_buf;
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                w_ram_en    = 1'b1;
                w_ram_addr  = i_rd_addr;
                w_state_nxt = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                w_rd_fire   = r_wait == 8'(RAM_LAT - 1);
                w_state_nxt = w_rd_fire ? ST_IDLE : ST_RDWAIT;
            end
            default:
                w_state_nxt = ST_CLEAR;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_addr  <= '0;
            r_wr_buf   <= '0;
            r_wr_pend  <= 1'b0;
            r_wait     <= '0;
            r_rd_ack   <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : r_clr_addr;
            r_wait     <= (r_state == ST_RDWAIT) ? r_wait + 1'b1 : '0;
            r_wr_pend  <= w_word_done || (r_wr_pend && r_state != ST_WR);
            if (w_word_done) begin
                r_wr_buf  <= w_word;
                r_wr_addr <= w_word_addr;
            end
            r_rd_ack   <= w_rd_fire;
            if (w_rd_fire)
                r_rd_data <= i_ram_dout;
            r_done     <= w_finish;
        end
    end
    // Port strobes and busy are forced low while reset is held so nothing is written during reset.
    assign o_ram_en   = w_ram_en && !i_rst;
    assign o_ram_we   = w_ram_we && !i_rst;
    assign o_ram_addr = w_ram_addr;
    assign o_ram_din  = w_ram_din;
    assign o_busy     = !i_rst && ((r_state == ST_CLEAR) || w_open);
    assign o_rd_ack   = r_rd_ack;
    assign o_rd_data  = r_rd_data;
    assign o_done     = r_done;
    assign o_overflow = w_overflow;
endmodule

// File: tb/tb_verdict_ram_scheduler.sv
// tb_verdict_ram_scheduler: directed bench for verdict_ram_scheduler with a 1-cycle RAM model
module tb_verdict_ram_scheduler;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_verdict_valid = 1'b0;
    logic        i_verdict_bit = 1'b0;
    logic [15:0] i_flow_total = '0;
    logic        i_rd_req = 1'b0;
    logic [1:0]  i_rd_addr = '0;
    logic        o_rd_ack;
    logic [63:0] o_rd_data;
    logic        o_done;
    logic        o_overflow;
    logic        o_busy;
    logic        o_ram_en;
    logic        o_ram_we;
    logic [1:0]  o_ram_addr;
    logic [63:0] o_ram_din;
    logic [63:0] ram_dout = '0;
    logic [63:0] mem [4] = '{default: 64'hDEAD_BEEF_DEAD_BEEF};
    int          n_wr = 0;
    int          n_done = 0;
    int          n_ack = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          w0;
    int          d0;
    int          a0;
    always #5 i_clk = ~i_clk;
    verdict_ram_scheduler dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_verdict_valid (i_verdict_valid),
        .i_verdict_bit   (i_verdict_bit),
        .i_flow_total    (i_flow_total),
        .i_rd_req        (i_rd_req),
        .i_rd_addr       (i_rd_addr),
        .o_rd_ack        (o_rd_ack),
        .o_rd_data       (o_rd_data),
        .o_done          (o_done),
        .o_overflow      (o_overflow),
        .o_busy          (o_busy),
        .o_ram_en        (o_ram_en),
        .o_ram_we        (o_ram_we),
        .o_ram_addr      (o_ram_addr),
        .o_ram_din       (o_ram_din),
        .i_ram_dout      (ram_dout)
    );
    always @(posedge i_clk) begin
        if (o_ram_en && o_ram_we) begin
            mem[o_ram_addr] <= o_ram_din;
            n_wr <= n_wr + 1;
        end
        if (o_ram_en && !o_ram_we)
            ram_dout <= mem[o_ram_addr];
        if (o_done)
            n_done <= n_done + 1;
        if (o_rd_ack)
            n_ack <= n_ack + 1;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(negedge i_clk);
    endtask
    task automatic vdt(input logic b);
        i_verdict_valid = 1'b1;
        i_verdict_bit = b;
        @(negedge i_clk);
        i_verdict_valid = 1'b0;
    endtask
    initial begin
        cyc();
        cyc();
        chk("rst_en", 64'(o_ram_en), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        chk("rst_ack", 64'(o_rd_ack), 64'd0);
        i_rst = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            if (a > 0)
                cyc();
            chk("clr_en_we", 64'({o_ram_en, o_ram_we}), 64'd3);
            chk("clr_addr", 64'(o_ram_addr), 64'(a));
            chk("clr_din", o_ram_din, 64'd0);
            chk("clr_busy", 64'(o_busy), 64'd1);
        end
        cyc();
        chk("clr_end_en", 64'(o_ram_en), 64'd0);
        chk("clr_end_busy", 64'(o_busy), 64'd0);
        for (int a = 0; a < 4; a++)
            chk("clr_mem", mem[a], 64'd0);
        i_flow_total = 16'd64;
        for (int k = 0; k < 64; k++)
            vdt(~k[0]);
        chk("t2_idle_en", 64'(o_ram_en), 64'd0);
        chk("t2_busy", 64'(o_busy), 64'd1);
        cyc();
        chk("t2_wr_en_we", 64'({o_ram_en, o_ram_we}), 64'd3);
        chk("t2_wr_addr", 64'(o_ram_addr), 64'd0);
        chk("t2_wr_din", o_ram_din, 64'h5555_5555_5555_5555);
        chk("t2_done_early", 64'(o_done), 64'd0);
        cyc();
        chk("t2_done", 64'(o_done), 64'd1);
        cyc();
        chk("t2_done_pulse", 64'(o_done), 64'd0);
        chk("t2_busy_end", 64'(o_busy), 64'd0);
        chk("t2_mem0", mem[0], 64'h5555_5555_5555_5555);
        i_flow_total = 16'd70;
        w0 = n_wr;
        d0 = n_done;
        for (int k = 0; k < 70; k++)
            vdt(1'b1);
        repeat (6) cyc();
        chk("t3_writes", 64'(n_wr - w0), 64'd2);
        chk("t3_done_cnt", 64'(n_done - d0), 64'd1);
        chk("t3_mem0", mem[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_mem1", mem[1], 64'h3F);
        chk("t3_ovf", 64'(o_overflow), 64'd0);
        i_flow_total = 16'd65;
        for (int k = 0; k < 64; k++)
            vdt(1'b0);
        repeat (3) cyc();
        vdt(1'b1);
        i_rd_req = 1'b1;
        i_rd_addr = 2'd1;
        chk("t4_idle_en", 64'(o_ram_en), 64'd0);
        cyc();
        chk("t4_wr_en_we", 64'({o_ram_en, o_ram_we}), 64'd3);
        chk("t4_wr_addr", 64'(o_ram_addr), 64'd1);
        chk("t4_wr_din", o_ram_din, 64'd1);
        cyc();
        chk("t4_gap_en", 64'(o_ram_en), 64'd0);
        chk("t4_done", 64'(o_done), 64'd1);
        cyc();
        chk("t4_rd_en_we", 64'({o_ram_en, o_ram_we}), 64'd2);
        chk("t4_rd_addr", 64'(o_ram_addr), 64'd1);
        cyc();
        chk("t4_ack_early", 64'(o_rd_ack), 64'd0);
        cyc();
        chk("t4_ack", 64'(o_rd_ack), 64'd1);
        chk("t4_rd_data", o_rd_data, 64'd1);
        i_rd_req = 1'b0;
        cyc();
        chk("t4_ack_pulse", 64'(o_rd_ack), 64'd0);
        chk("t4_no_reissue", 64'(o_ram_en), 64'd0);
        chk("t4_mem0", mem[0], 64'd0);
        i_flow_total = 16'd300;
        w0 = n_wr;
        d0 = n_done;
        for (int k = 0; k < 256; k++)
            vdt(1'b1);
        chk("t5_ovf_256", 64'(o_overflow), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd1);
        vdt(1'b1);
        chk("t5_ovf_257", 64'(o_overflow), 64'd1);
        for (int k = 0; k < 42; k++)
            vdt(1'b1);
        cyc();
        chk("t5_done_299", 64'(n_done - d0), 64'd0);
        vdt(1'b1);
        repeat (3) cyc();
        chk("t5_done_cnt", 64'(n_done - d0), 64'd1);
        chk("t5_writes", 64'(n_wr - w0), 64'd4);
        chk("t5_busy_end", 64'(o_busy), 64'd0);
        for (int a = 0; a < 4; a++)
            chk("t5_mem", mem[a], 64'hFFFF_FFFF_FFFF_FFFF);
        i_rd_req = 1'b1;
        i_rd_addr = 2'd2;
        cyc();
        chk("t6_rd_en_we", 64'({o_ram_en, o_ram_we}), 64'd2);
        chk("t6_rd_addr", 64'(o_ram_addr), 64'd2);
        i_rst = 1'b1;
        i_rd_req = 1'b0;
        a0 = n_ack;
        cyc();
        chk("t6_rst_ack", 64'(o_rd_ack), 64'd0);
        chk("t6_rst_en", 64'(o_ram_en), 64'd0);
        chk("t6_rst_ovf", 64'(o_overflow), 64'd0);
        cyc();
        i_rst = 1'b0;
        #1;
        chk("t6_clr_en_we", 64'({o_ram_en, o_ram_we}), 64'd3);
        chk("t6_clr_addr", 64'(o_ram_addr), 64'd0);
        chk("t6_clr_busy", 64'(o_busy), 64'd1);
        repeat (4) cyc();
        chk("t6_idle_busy", 64'(o_busy), 64'd0);
        chk("t6_no_ack", 64'(n_ack - a0), 64'd0);
        chk("t6_mem3", mem[3], 64'd0);
        i_flow_total = 16'd0;
        w0 = n_wr;
        d0 = n_done;
        vdt(1'b1);
        chk("t6_zero_ovf", 64'(o_overflow), 64'd1);
        chk("t6_zero_busy", 64'(o_busy), 64'd0);
        repeat (3) cyc();
        chk("t6_zero_writes", 64'(n_wr - w0), 64'd0);
        chk("t6_zero_done", 64'(n_done - d0), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
